// File: rtl/tohost_monitor_pkg.sv
// tohost_monitor_pkg: shared types and word-alignment helpers for the tohost monitor
package tohost_monitor_pkg;

    typedef enum logic [1:0] {NONE = 2'd0, TOHOST = 2'd1, TIMEOUT = 2'd2} halt_cause_e;
    typedef enum logic [2:0] {RUN, READ, WAIT, EMIT, DONE} mon_state_e;

    // Helpers work on the widest supported address; callers truncate, so a
    // rounded-up end past the top of the space wraps to 0 and reads as empty.
    localparam int MAX_ADDR_W = 64;

    function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] addr, input int data_w);
        return addr & ~MAX_ADDR_W'(data_w / 8 - 1);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] word_align_up(input logic [MAX_ADDR_W-1:0] addr, input int data_w);
        return word_align(addr + MAX_ADDR_W'(data_w / 8 - 1), data_w);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: saturating enable-gated cycle counter with a one-shot limit compare
module cycle_timer #(
    parameter int          CNT_W = 32,
    parameter int unsigned LIMIT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en && count != '1)
            count <= count + CNT_W'(1);
    end

    assign expired = en && (LIMIT != 0) && count == CNT_W'(LIMIT - 1);

endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: halts on a tohost write or timeout, then streams the signature region
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cfg_tohost,
    input  logic [ADDR_W-1:0] cfg_sig_begin,
    input  logic [ADDR_W-1:0] cfg_sig_end,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sig_valid,
    output logic [DATA_W-1:0] sig_data,
    output logic              sig_last,
    input  logic              sig_ready,
    output logic              done,
    output logic [1:0]        halt_cause,
    output logic [DATA_W-1:0] tohost_value,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    mon_state_e        state, state_n;
    halt_cause_e       cause;
    logic [ADDR_W-1:0] ptr, sig_begin, sig_end;
    logic              hit, expired, halt, empty, fire;

    assign sig_begin = ADDR_W'(word_align(MAX_ADDR_W'(cfg_sig_begin), DATA_W));
    assign sig_end   = ADDR_W'(word_align_up(MAX_ADDR_W'(cfg_sig_end), DATA_W));
    assign empty     = sig_end <= sig_begin;
    assign hit       = state == RUN && mem_we && mem_wdata != '0 &&
                       word_align(MAX_ADDR_W'(mem_addr), DATA_W) == word_align(MAX_ADDR_W'(cfg_tohost), DATA_W);
    assign halt      = hit || (state == RUN && expired);
    assign fire      = sig_valid && sig_ready;

    cycle_timer #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (state == RUN),
        .count   (cycle_count),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (halt) state_n = empty ? DONE : READ;
            READ:    state_n = WAIT;
            WAIT:    state_n = EMIT;
            EMIT:    if (fire) state_n = sig_last ? DONE : READ;
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            sig_valid    <= 1'b0;
            sig_data     <= '0;
            sig_last     <= 1'b0;
            cause        <= NONE;
            tohost_value <= '0;
        end else begin
            if (halt) begin
                ptr   <= sig_begin;
                cause <= hit ? TOHOST : TIMEOUT;
                if (hit)
                    tohost_value <= mem_wdata;
            end
            if (state == WAIT) begin
                sig_data  <= rd_data;
                sig_valid <= 1'b1;
                sig_last  <= (ptr + WORD_BYTES) >= sig_end;
            end
            if (state == EMIT && fire) begin
                sig_valid <= 1'b0;
                ptr       <= ptr + WORD_BYTES;
            end
        end
    end

    assign rd_en      = state == READ;
    assign rd_addr    = ptr;
    assign done       = state == DONE;
    assign halt_cause = cause;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: randomized scoreboard bench for tohost_monitor
module tb_tohost_monitor;

    localparam int TO = 100;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] cfg_tohost = 0, cfg_sig_begin = 0, cfg_sig_end = 0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data = 0;
    logic        sig_valid, sig_last, done;
    logic        sig_ready = 1'b0;
    logic [31:0] sig_data, tohost_value, cycle_count;
    logic [1:0]  halt_cause;

    int          tests = 0, fails = 0, n_popped = 0;
    word_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];

    tohost_monitor #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_tohost   (cfg_tohost),
        .cfg_sig_begin(cfg_sig_begin),
        .cfg_sig_end  (cfg_sig_end),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sig_valid    (sig_valid),
        .sig_data     (sig_data),
        .sig_last     (sig_last),
        .sig_ready    (sig_ready),
        .done         (done),
        .halt_cause   (halt_cause),
        .tohost_value (tohost_value),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    // Memory read port: data appears the cycle after the request
    always @(posedge clk)
        if (rd_en) rd_data <= mem.exists(rd_addr) ? mem[rd_addr] : (32'hDEAD0000 ^ rd_addr);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {sig_valid, sig_last, sig_data}, {1'b1, prev_last, prev_data});
            if (sig_valid && sig_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected no word", sig_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("sig_word", {sig_last, sig_data}, {w.last, w.data});
                    n_popped++;
                end
            end
            prev_stall = sig_valid && !sig_ready;
            prev_data  = sig_data;
            prev_last  = sig_last;
        end
    end

    task automatic check_reset_vals(input string name);
        check({name, "_ctl"}, {rd_en, sig_valid, sig_last, done, halt_cause}, 64'd0);
        check({name, "_rd_addr"}, rd_addr, 64'd0);
        check({name, "_sig_data"}, sig_data, 64'd0);
        check({name, "_tohost"}, tohost_value, 64'd0);
        check({name, "_count"}, cycle_count, 64'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 0;
        mem_wdata = 0;
        sig_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
    endtask

    task automatic run_case(input string name, input logic [31:0] b, input logic [31:0] e, input int hit_c,
                            input logic [31:0] hit_d, input bit rand_ready, input int abort_after, input bit seq_data);
        int     halt_c, n, c, done_c, first_rd, first_v;
        longint lo, hi;
        bit     hit_ok;
        logic [31:0] tv, cc;
        cfg_tohost    = 32'h2000;
        cfg_sig_begin = b;
        cfg_sig_end   = e;
        do_reset();
        hit_ok = hit_c >= 0 && hit_c < TO;
        halt_c = hit_ok ? hit_c : TO - 1;
        lo = longint'(b) & ~longint'(3);
        hi = (longint'(e) + 3) & ~longint'(3);
        if (hi > 64'hFFFF_FFFF) hi = 0;
        n = 0;
        for (longint a = lo; a < hi; a += 4) begin
            mem[32'(a)] = seq_data ? 32'hA0 + 32'(n) : $urandom;
            exp_q.push_back('{data: mem[32'(a)], last: (a + 4 >= hi)});
            n++;
        end
        c = 0; done_c = -1; first_rd = -1; first_v = -1; n_popped = 0;
        while (done_c < 0 && c < 3000) begin
            if (hit_ok && c == hit_c) begin
                mem_we = 1'b1; mem_addr = 32'h2000 | $urandom_range(0, 3); mem_wdata = hit_d;
            end else if (c > halt_c) begin
                mem_we = 1'($urandom_range(0, 1)); mem_addr = 32'h2000; mem_wdata = $urandom | 32'h1;
            end else if (c == 30 || $urandom_range(0, 3) == 0) begin
                mem_we = 1'b1; mem_addr = 32'h2000 | $urandom_range(0, 3); mem_wdata = 0;
            end else begin
                mem_we = 1'($urandom_range(0, 1)); mem_addr = 32'h3000 + 4 * $urandom_range(0, 255); mem_wdata = $urandom;
            end
            sig_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_after > 0 && n_popped >= abort_after && sig_valid) begin
                reset     = 1'b1;
                sig_ready = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                check_reset_vals({name, "_midreset"});
                return;
            end
            if (rd_en && first_rd < 0) first_rd = c;
            if (sig_valid && first_v < 0) first_v = c;
            if (done) done_c = c;
            else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        if (done_c < 0) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout: got no done expected done", name);
        end
        check({name, "_cause"}, halt_cause, hit_ok ? 64'd1 : 64'd2);
        check({name, "_tohost"}, tohost_value, hit_ok ? {32'd0, hit_d} : 64'd0);
        check({name, "_count"}, cycle_count, 64'(halt_c + 1));
        if (n == 0) begin
            check({name, "_done_cycle"}, 64'(done_c), 64'(halt_c + 1));
            check({name, "_no_valid"}, 64'(first_v), 64'(-1));
        end else begin
            check({name, "_first_rd"}, 64'(first_rd), 64'(halt_c + 1));
            check({name, "_first_valid"}, 64'(first_v), 64'(halt_c + 3));
            if (!rand_ready) check({name, "_done_cycle"}, 64'(done_c), 64'(halt_c + 1 + 3 * n));
        end
        tv = tohost_value;
        cc = cycle_count;
        repeat (4) begin
            mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = $urandom | 32'h1; sig_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        check({name, "_frozen"}, {done, tohost_value, cycle_count}, {1'b1, tv, cc});
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        run_case("happy", 32'h1000, 32'h1010, 50, 32'h1, 1'b0, 0, 1'b1);
        run_case("zero_timeout", 32'h1000, 32'h1010, -1, 0, 1'b0, 0, 1'b0);
        run_case("simultaneous", 32'h1000, 32'h1010, TO - 1, $urandom | 32'h1, 1'b0, 0, 1'b0);
        run_case("backpressure", 32'h1002, 32'h100D, 40, $urandom | 32'h1, 1'b1, 0, 1'b0);
        run_case("empty", 32'h1000, 32'h1000, 20, $urandom | 32'h1, 1'b1, 0, 1'b0);
        run_case("wrap_empty", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 25, $urandom | 32'h1, 1'b0, 0, 1'b0);
        run_case("mid_reset", 32'h1000, 32'h1020, 30, $urandom | 32'h1, 1'b1, 3, 1'b0);
        run_case("after_reset", 32'h1000, 32'h1020, 35, $urandom | 32'h1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rb;
            rb = 32'h4000 + $urandom_range(0, 15);
            run_case("random", rb, rb + $urandom_range(0, 40),
                     ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(5, 110)),
                     $urandom | 32'h1, 1'($urandom_range(0, 1)), 0, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
